instr_fetch_unit: RTL

- Initiator side of the instruction-memory read interface.
- Owns the PC and drives a 64-bit byte address to the combinational instruction memory, which returns the 32-bit instruction in the same cycle.
- Buffers each fetched {pc, instr} pair in a small FIFO and hands it to decode with a valid/ready handshake.
- Handles branch redirects (flush) and halts on ECALL or on an out-of-range PC.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    localparam logic [31:0] ECALL_OPCODE = 32'h00000073;
    localparam logic [31:0] NOP_INSTR    = 32'h00000013;
    localparam int unsigned INSTR_BYTES  = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake: head of the fetch FIFO offered with valid/ready.
interface instr_fetch_unit_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;

    modport master (output if_valid, output if_instr, output if_pc, input id_ready);
    modport slave  (input if_valid, input if_instr, input if_pc, output id_ready);
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} fetch entries; flush beats push and pop.
module instr_fetch_unit_fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, imem request, fetch FIFO, redirect and halt control.
// Optional perf counters are enabled with `define INSTR_FETCH_PERF_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned IMEM_BYTES = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [63:0]               imem_addr,
    input  logic [31:0]               imem_instr,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    instr_fetch_unit_if.master        id_bus,
    output logic                      halted
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_stall
`endif
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam logic [63:0] PC_LAST = 64'(IMEM_BYTES - INSTR_BYTES);

    state_e           state_q;
    logic [63:0]      pc_q;
    logic             in_range, pop, fetch, is_ecall;
    fetch_entry_t     head, push_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             unused_count;

    assign in_range   = (pc_q <= PC_LAST);
    assign pop        = id_bus.if_valid && id_bus.id_ready;
    assign fetch      = (state_q == RUN) && !redirect_valid && in_range && (!fifo_full || pop);
    assign is_ecall   = (imem_instr == ECALL_OPCODE);
    assign push_entry = '{pc: pc_q, instr: imem_instr};
    assign unused_count = ^fifo_count;

    instr_fetch_unit_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (fetch),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc & ~64'h3;
            state_q <= RUN;
        end else if (state_q == RUN) begin
            if (!in_range) begin
                state_q <= HALT;
            end else if (fetch) begin
                // ECALL is delivered but fetch parks on it.
                if (is_ecall) state_q <= HALT;
                else          pc_q    <= pc_q + 64'(INSTR_BYTES);
            end
        end
    end

    assign imem_addr       = pc_q;
    assign halted          = (state_q == HALT);
    assign id_bus.if_valid = !fifo_empty;
    assign id_bus.if_instr = fifo_empty ? 32'h0 : head.instr;
    assign id_bus.if_pc    = fifo_empty ? 64'h0 : head.pc;

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fetch && perf_fetched != 32'hFFFFFFFF) perf_fetched <= perf_fetched + 32'd1;
            if ((state_q == RUN) && fifo_full && !pop && perf_stall != 32'hFFFFFFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
